// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory access path: funct3 sizes, writeback
// select values and byte-lane masks used by the store merge.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Access size is funct3[1:0]; the top bit only selects zero-extension.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] LANE_NONE = 4'b0000;
  localparam logic [3:0] LANE_B0   = 4'b0001;
  localparam logic [3:0] LANE_H_LO = 4'b0011;
  localparam logic [3:0] LANE_H_HI = 4'b1100;
  localparam logic [3:0] LANE_ALL  = 4'b1111;

  function automatic logic [31:0] laneMerge(input logic [3:0] mask,
                                            input logic [31:0] newWord,
                                            input logic [31:0] oldWord);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? newWord[8*i +: 8] : oldWord[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: store merge into the read word, load
// lane select with sign/zero extension, and alignment fault detection.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [2:0]  funct3,
  input  logic [31:0] storeData,
  input  logic [31:0] readWord,
  output logic [31:0] mergedWord,
  output logic [31:0] loadData,
  output logic        misaligned
);

  logic [3:0]  laneMask;
  logic [31:0] storeLanes;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Store lanes are replicated so the mask alone picks the bytes written.
  always_comb begin
    laneMask   = LANE_NONE;
    storeLanes = storeData;
    misaligned = 1'b0;
    case (funct3[1:0])
      SZ_BYTE: begin
        laneMask   = LANE_B0 << addrLo;
        storeLanes = {4{storeData[7:0]}};
      end
      SZ_HALF: begin
        laneMask   = addrLo[1] ? LANE_H_HI : LANE_H_LO;
        storeLanes = {2{storeData[15:0]}};
        misaligned = addrLo[0];
      end
      SZ_WORD: begin
        laneMask   = LANE_ALL;
        misaligned = funct3[2] | (addrLo != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
    mergedWord = laneMerge(laneMask, storeLanes, readWord);
  end

  assign byteSel = readWord[{addrLo, 3'b000} +: 8];
  assign halfSel = readWord[{addrLo[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      F3_B:    loadData = {{24{byteSel[7]}}, byteSel};
      F3_BU:   loadData = {24'd0, byteSel};
      F3_H:    loadData = {{16{halfSel[15]}}, halfSel};
      F3_HU:   loadData = {16'd0, halfSel};
      default: loadData = readWord;
    endcase
  end

endmodule

// File: rtl/mem_wb_lsu.sv
// Load/store unit feeding the MEM/WB pipeline register, with access-fault
// detection and a sticky first-fault record.
module mem_wb_lsu
  import riscv_mem_pkg::*;
#(
  parameter int DMEM_ADDR_BITS = 8,
  parameter bit RANGE_CHECK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic        mem_write_m,
  input  logic        mem_read_m,
  input  logic [2:0]  funct3_m,
  input  logic [4:0]  rd_m,
  input  logic        reg_write_m,
  input  logic [1:0]  result_src_m,
  input  logic [31:0] pc_plus4_m,
  input  logic [31:0] dmem_rdata,
  input  logic        stall_w,
  input  logic        flush_w,
  input  logic        fault_clr,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  output logic        valid_w,
  output logic        reg_write_w,
  output logic        exc_w,
  output logic [4:0]  rd_w,
  output logic [1:0]  result_src_w,
  output logic [31:0] alu_result_w,
  output logic [31:0] read_data_w,
  output logic [31:0] pc_plus4_w,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic        fault_is_store
);

  localparam logic [31:0] HIGH_MASK = ~((32'd1 << DMEM_ADDR_BITS) - 32'd1);

  logic        access;
  logic        misaligned;
  logic        outOfRange;
  logic        bad;
  logic        advance;
  logic        faultCapture;
  logic [31:0] loadData;

  lsu_align uAlign (
    .addrLo     (alu_result_m[1:0]),
    .funct3     (funct3_m),
    .storeData  (write_data_m),
    .readWord   (dmem_rdata),
    .mergedWord (dmem_wdata),
    .loadData   (loadData),
    .misaligned (misaligned)
  );

  assign access       = valid_m & (mem_read_m | mem_write_m);
  assign outOfRange   = RANGE_CHECK && ((alu_result_m & HIGH_MASK) != 32'd0);
  assign bad          = access & (misaligned | outOfRange);
  assign advance      = ~stall_w & ~flush_w;
  assign faultCapture = advance & bad & (~fault_valid | fault_clr);

  // Write only on the cycle the store leaves MEM, so a stall never double-writes.
  assign dmem_addr = alu_result_m;
  assign dmem_we   = valid_m & mem_write_m & ~bad & ~stall_w;

  // MEM/WB register: flush clears control bits only, data fields hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      exc_w        <= 1'b0;
      rd_w         <= 5'd0;
      result_src_w <= RES_ALU;
      alu_result_w <= 32'd0;
      read_data_w  <= 32'd0;
      pc_plus4_w   <= 32'd0;
    end else if (flush_w) begin
      valid_w     <= 1'b0;
      reg_write_w <= 1'b0;
      exc_w       <= 1'b0;
    end else if (!stall_w) begin
      valid_w      <= valid_m;
      reg_write_w  <= reg_write_m & valid_m & ~bad;
      exc_w        <= bad;
      rd_w         <= rd_m;
      result_src_w <= result_src_m;
      alu_result_w <= alu_result_m;
      read_data_w  <= loadData;
      pc_plus4_w   <= pc_plus4_m;
    end
  end

  // First fault wins; a clear on the same edge as a new fault keeps the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_valid    <= 1'b0;
      fault_addr     <= 32'd0;
      fault_is_store <= 1'b0;
    end else if (faultCapture) begin
      fault_valid    <= 1'b1;
      fault_addr     <= alu_result_m;
      fault_is_store <= mem_write_m;
    end else if (fault_clr) begin
      fault_valid    <= 1'b0;
      fault_addr     <= 32'd0;
      fault_is_store <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_lsu.sv
// Randomized self-checking bench for mem_wb_lsu against a byte-level
// reference model of the access rules and the MEM/WB/fault registers.
module tb_mem_wb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_m, mem_write_m, mem_read_m, reg_write_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m, dmem_rdata;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [1:0]  result_src_m;
  logic        stall_w, flush_w, fault_clr;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_we, valid_w, reg_write_w, exc_w;
  logic [4:0]  rd_w;
  logic [1:0]  result_src_w;
  logic [31:0] alu_result_w, read_data_w, pc_plus4_w;
  logic        fault_valid, fault_is_store;
  logic [31:0] fault_addr;

  int nCompared = 0;
  int nMismatched = 0;

  // reference state
  logic        mValid, mRegWrite, mExc, mFv, mFst;
  logic [4:0]  mRd;
  logic [1:0]  mRes;
  logic [31:0] mAlu, mLoad, mPc, mFaddr;

  mem_wb_lsu #(.DMEM_ADDR_BITS(8), .RANGE_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .mem_write_m(mem_write_m), .mem_read_m(mem_read_m),
    .funct3_m(funct3_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .pc_plus4_m(pc_plus4_m), .dmem_rdata(dmem_rdata),
    .stall_w(stall_w), .flush_w(flush_w), .fault_clr(fault_clr),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .exc_w(exc_w), .rd_w(rd_w),
    .result_src_w(result_src_w), .alu_result_w(alu_result_w),
    .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_is_store(fault_is_store)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic refMis(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = accessSize(f3);
    if (sz == 0) return 1'b1;
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [31:0] refMerge(input logic [31:0] a, input logic [2:0] f3,
                                           input logic [31:0] wd, input logic [31:0] old);
    logic [7:0] b [4];
    int sz, base;
    sz = accessSize(f3);
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    base = (sz == 4) ? 0 : (sz == 2) ? 2 * int'(a[1]) : int'(a[1:0]);
    for (int k = 0; k < sz; k++) b[base + k] = wd[8*k +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [2:0] f3,
                                          input logic [31:0] w);
    int sz, off;
    logic [31:0] v;
    sz = accessSize(f3);
    if (sz == 0 || sz == 4) return w;
    off = (sz == 2) ? 2 * int'(a[1]) : int'(a[1:0]);
    v = w >> (8 * off);
    if (sz == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic modelReset();
    mValid = 1'b0; mRegWrite = 1'b0; mExc = 1'b0; mRd = 5'd0; mRes = 2'd0;
    mAlu = 32'd0; mLoad = 32'd0; mPc = 32'd0; mFv = 1'b0; mFaddr = 32'd0; mFst = 1'b0;
  endtask

  task automatic chkRegs();
    chk("valid_w", 32'(valid_w), 32'(mValid));
    chk("reg_write_w", 32'(reg_write_w), 32'(mRegWrite));
    chk("exc_w", 32'(exc_w), 32'(mExc));
    chk("rd_w", 32'(rd_w), 32'(mRd));
    chk("result_src_w", 32'(result_src_w), 32'(mRes));
    chk("alu_result_w", alu_result_w, mAlu);
    chk("read_data_w", read_data_w, mLoad);
    chk("pc_plus4_w", pc_plus4_w, mPc);
    chk("fault_valid", 32'(fault_valid), 32'(mFv));
    if (mFv) begin
      chk("fault_addr", fault_addr, mFaddr);
      chk("fault_is_store", 32'(fault_is_store), 32'(mFst));
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_valid"}, 32'(valid_w), 32'd0);
    chk({tag, "_regw"}, 32'(reg_write_w), 32'd0);
    chk({tag, "_exc"}, 32'(exc_w), 32'd0);
    chk({tag, "_rd"}, 32'(rd_w), 32'd0);
    chk({tag, "_res"}, 32'(result_src_w), 32'd0);
    chk({tag, "_alu"}, alu_result_w, 32'd0);
    chk({tag, "_rdata"}, read_data_w, 32'd0);
    chk({tag, "_pc4"}, pc_plus4_w, 32'd0);
    chk({tag, "_fv"}, 32'(fault_valid), 32'd0);
    chk({tag, "_faddr"}, fault_addr, 32'd0);
    chk({tag, "_fst"}, 32'(fault_is_store), 32'd0);
  endtask

  // Inputs are already applied; check combinational outputs, advance model, clock, check registers.
  task automatic cycle();
    logic acc, bad;
    logic [31:0] ld;
    #1;
    acc = valid_m & (mem_read_m | mem_write_m);
    bad = acc & (refMis(funct3_m, alu_result_m) | (alu_result_m > 32'd255));
    chk("dmem_addr", dmem_addr, alu_result_m);
    chk("dmem_we", 32'(dmem_we), 32'(valid_m & mem_write_m & ~bad & ~stall_w));
    if (mem_write_m && !refMis(funct3_m, alu_result_m))
      chk("dmem_wdata", dmem_wdata, refMerge(alu_result_m, funct3_m, write_data_m, dmem_rdata));
    ld = refLoad(alu_result_m, funct3_m, dmem_rdata);
    if (flush_w) begin
      mValid = 1'b0; mRegWrite = 1'b0; mExc = 1'b0;
    end else if (!stall_w) begin
      mValid = valid_m; mExc = bad; mRegWrite = reg_write_m & valid_m & ~bad;
      mRd = rd_m; mRes = result_src_m; mAlu = alu_result_m; mLoad = ld; mPc = pc_plus4_m;
    end
    if (!stall_w && !flush_w && bad && (!mFv || fault_clr)) begin
      mFv = 1'b1; mFaddr = alu_result_m; mFst = mem_write_m;
    end else if (fault_clr) begin
      mFv = 1'b0;
    end
    @(posedge clk);
    #1;
    chkRegs();
  endtask

  task automatic setIn(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata);
    valid_m = v; mem_read_m = rd; mem_write_m = wr; funct3_m = f3;
    alu_result_m = a; write_data_m = wd; dmem_rdata = rdata;
    reg_write_m = rd; rd_m = 5'($urandom); result_src_m = rd ? 2'b01 : 2'b00;
    pc_plus4_m = $urandom; stall_w = 1'b0; flush_w = 1'b0; fault_clr = 1'b0;
  endtask

  logic [2:0] f3Tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] f3Bad [3] = '{3'd3, 3'd6, 3'd7};

  initial begin
    int op;
    modelReset();
    rst_n = 1'b0;
    setIn(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    #3;
    chkAllZero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SB lane 1
    setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h05, 32'h0000_00AB, 32'h1122_3344);
    #1;
    chk("sb_merge", dmem_wdata, 32'h1122_AB44);
    chk("sb_we", 32'(dmem_we), 32'd1);
    cycle();
    chk("sb_exc", 32'(exc_w), 32'd0);

    // LH / LHU on upper half
    setIn(1'b1, 1'b1, 1'b0, 3'b001, 32'h06, 32'd0, 32'h8001_7FFF);
    cycle();
    chk("lh_sext", read_data_w, 32'hFFFF_8001);
    setIn(1'b1, 1'b1, 1'b0, 3'b101, 32'h06, 32'd0, 32'h8001_7FFF);
    cycle();
    chk("lhu_zext", read_data_w, 32'h0000_8001);

    // fault sequence
    setIn(1'b1, 1'b0, 1'b1, 3'b010, 32'h0A, 32'h1234_5678, 32'd0);
    #1;
    chk("sw_mis_we", 32'(dmem_we), 32'd0);
    cycle();
    chk("sw_mis_exc", 32'(exc_w), 32'd1);
    chk("sw_mis_regw", 32'(reg_write_w), 32'd0);
    chk("sw_mis_fv", 32'(fault_valid), 32'd1);
    chk("sw_mis_faddr", fault_addr, 32'h0A);
    chk("sw_mis_fst", 32'(fault_is_store), 32'd1);
    setIn(1'b1, 1'b1, 1'b0, 3'b010, 32'h03, 32'd0, 32'h5555_AAAA);
    cycle();
    chk("first_fault_wins", fault_addr, 32'h0A);
    setIn(1'b1, 1'b1, 1'b0, 3'b001, 32'h101, 32'd0, 32'h0);
    fault_clr = 1'b1;
    cycle();
    chk("clr_new_faddr", fault_addr, 32'h101);
    chk("clr_new_fst", 32'(fault_is_store), 32'd0);
    setIn(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    fault_clr = 1'b1;
    cycle();
    chk("clr_fv", 32'(fault_valid), 32'd0);

    // stalled store writes only on release
    for (int i = 0; i < 3; i++) begin
      setIn(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0);
      stall_w = 1'b1;
      cycle();
    end
    setIn(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0);
    #1;
    chk("stall_release_we", 32'(dmem_we), 32'd1);
    chk("stall_release_wdata", dmem_wdata, 32'hDEAD_BEEF);
    cycle();

    // flush beats stall; a flushed misaligned access does not fault
    setIn(1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 32'h0BAD_F00D);
    stall_w = 1'b1; flush_w = 1'b1;
    cycle();
    chk("flush_valid", 32'(valid_w), 32'd0);
    chk("flush_regw", 32'(reg_write_w), 32'd0);
    setIn(1'b1, 1'b1, 1'b0, 3'b010, 32'h22, 32'd0, 32'h0);
    flush_w = 1'b1;
    cycle();
    chk("flush_no_fault", 32'(fault_valid), 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 3);
      setIn(($urandom_range(0, 9) < 8), (op == 1 || op == 3), (op == 2),
            ($urandom_range(0, 9) < 8) ? f3Tab[$urandom_range(0, 4)] : f3Bad[$urandom_range(0, 2)],
            ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 255)) : 32'($urandom),
            $urandom, $urandom);
      stall_w   = ($urandom_range(0, 9) < 2);
      flush_w   = ($urandom_range(0, 9) < 1);
      fault_clr = ($urandom_range(0, 9) < 1);
      cycle();
    end

    // async reset mid-stall with a fault recorded
    setIn(1'b1, 1'b0, 1'b1, 3'b010, 32'h01, 32'h0, 32'h0);
    cycle();
    setIn(1'b1, 1'b1, 1'b0, 3'b000, 32'h40, 32'h0, 32'hFFFF_FFFF);
    stall_w = 1'b1;
    cycle();
    chk("pre_reset_fv", 32'(fault_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chkAllZero("async_rst");
    modelReset();
    #5;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_wb_lsu.md
Name: mem_wb_lsu

Overview:
Load/store access unit plus MEM/WB pipeline register, placed between the EX/MEM register and writeback. It drives the word-addressed data memory: sub-word stores are merged into the combinational read word. Load data is lane-selected and sign- or zero-extended. The unit detects misaligned and out-of-range accesses, latches a sticky fault record, and registers all writeback fields with stall and flush control.

Parameters:
DMEM_ADDR_BITS, 8, byte-address bits decoded by data memory (64 words); a nonzero bit above this is an access fault
RANGE_CHECK, 1, 1 enables the out-of-range check; 0 checks alignment only

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_m  in  1  MEM-stage instruction valid
alu_result_m  in  32  effective byte address / ALU result
write_data_m  in  32  store source register value
mem_write_m  in  1  store
mem_read_m  in  1  load
funct3_m  in  3  access size/sign (RV32I encoding)
rd_m  in  5  destination register
reg_write_m  in  1  register write enable
result_src_m  in  2  writeback mux select
pc_plus4_m  in  32  PC+4
dmem_rdata  in  32  combinational read word from data memory
stall_w  in  1  hold MEM/WB register
flush_w  in  1  insert bubble into MEM/WB
fault_clr  in  1  clear sticky fault
dmem_addr  out  32  memory address (= alu_result_m)
dmem_wdata  out  32  merged store word
dmem_we  out  1  memory write enable
valid_w, reg_write_w, exc_w  out  1 each  writeback valid, reg write, exception flag
rd_w  out  5  writeback register
result_src_w  out  2  writeback select
alu_result_w, read_data_w, pc_plus4_w  out  32 each  writeback data
fault_valid  out  1  sticky fault present
fault_addr  out  32  faulting byte address
fault_is_store  out  1  1 = faulting access was a store

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, including valid_w, reg_write_w, exc_w, all data fields and all fault_* outputs. Reset mid-stall or mid-fault discards all state.
- access = valid_m & (mem_read_m | mem_write_m).
- Misaligned when:
  - halfword (funct3[1:0]=01) and addr[0]=1
  - word (10) and addr[1:0]≠0
  - funct3 values 011/110/111 on an access are also treated as misaligned
- Out of range (RANGE_CHECK=1): addr[31:DMEM_ADDR_BITS]≠0.
- bad = access & (misaligned | out_of_range).
- Store merge, combinational:
  - SB writes lane addr[1:0] with write_data_m[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with write_data_m[15:0].
  - SW writes the full word.
  - Lanes not written take dmem_rdata.
- dmem_we = valid_m & mem_write_m & ~bad & ~stall_w. The write occurs only on the cycle the instruction leaves MEM. The merge is idempotent if it is ever repeated.
- Load extend: select the lane(s) per addr. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- MEM/WB register, latency 1: fields captured at the rising edge where stall_w=0.
  - flush_w=1 (wins over stall_w): valid_w, reg_write_w and exc_w load 0; data fields don't-care, implemented as hold.
  - stall_w=1, no flush: all fields hold.
  - Otherwise load: valid_w←valid_m, exc_w←bad, reg_write_w←reg_write_m & valid_m & ~bad, and all other fields from the M stage.
- Fault record:
  - On an advancing edge (stall_w=0, flush_w=0) with bad=1 and fault_valid=0, latch fault_valid=1, fault_addr=alu_result_m and fault_is_store=mem_write_m.
  - While fault_valid=1, later faults are ignored; the first fault wins.
  - fault_clr=1 clears the record. If fault_clr and a new fault occur on the same edge, the new fault is captured.
- Non-access instructions (mem_read_m=mem_write_m=0) never fault and never write.

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - result_src encodings: RES_ALU=00, RES_MEM=01, RES_PC4=10
  - lane-mask helper constants
- One combinational sub-module, lsu_align, takes addr[1:0], funct3, store data and read word. It returns the merged word, the extended load and the misaligned flag.
- The register and fault logic stays in mem_wb_lsu.

Test Plan:
- SB addr 0x05, wdata 0x000000AB, dmem_rdata 0x11223344 -> dmem_wdata 0x1122AB44, dmem_we=1; next cycle exc_w=0.
- LH addr 0x06, dmem_rdata 0x8001_7FFF -> read_data_w 0xFFFF8001; same access as LHU -> 0x00008001.
- SW addr 0x0A -> dmem_we=0; next cycle exc_w=1, reg_write_w=0, fault_valid=1, fault_addr=0x0A, fault_is_store=1. A second misaligned LW at 0x03 leaves fault_addr=0x0A. Then fault_clr together with an LH at 0x101 (out of range) gives fault_addr=0x101, fault_is_store=0.
- stall_w=1 for 3 cycles during SW 0x10 data 0xDEADBEEF -> dmem_we=0 while stalled, 1 on the release cycle; MEM/WB fields hold throughout.
- flush_w=1 together with stall_w=1 and valid LW -> valid_w=0, reg_write_w=0 next cycle; a misaligned access flushed this way sets no fault.
- Assert rst_n=0 asynchronously mid-stall with fault_valid=1 -> all outputs 0 immediately, with no clock edge required.
